// File: rtl/prbs_pattern_checker.sv
// Receive-side PRBS-15 checker: hunts for a repeated 32-bit sync pattern,
// self-seeds from the next two bytes, then counts bit/byte errors.
module prbs_pattern_checker #(
    parameter int ERR_W       = 16,
    parameter int LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    input  logic [31:0]      pattern,
    input  logic [3:0]       n,
    output logic             pattern_detected,
    output logic             prbs_locked,
    output logic [ERR_W-1:0] bit_err_cnt,
    output logic [ERR_W-1:0] byte_err_cnt,
    output logic             err_flag
);

    localparam int CONSEC_W = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        HUNT,
        SEED,
        CHECK
    } state_t;

    typedef struct packed {
        logic [14:0] next;
        logic [7:0]  pred;
    } lfsr_out_t;

    // Eight PRBS-15 steps; the first generated bit lands in pred[7].
    function automatic lfsr_out_t lfsr_step8(input logic [14:0] s_in);
        lfsr_out_t   r;
        logic [14:0] s;
        logic        nb;
        s = s_in;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            nb          = s[14] ^ s[13];
            r.pred[7-i] = nb;
            s           = {s[13:0], nb};
        end
        r.next = s;
        return r;
    endfunction

    state_t                state, state_nxt;
    logic [1:0]            byte_idx, byte_idx_nxt;
    logic [3:0]            rep_cnt, rep_cnt_nxt;
    logic                  seed_cnt, seed_cnt_nxt;
    logic [7:0]            seed_byte, seed_byte_nxt;
    logic [14:0]           lfsr, lfsr_nxt;
    logic [CONSEC_W-1:0]   consec_err, consec_err_nxt;
    logic                  detected_nxt, locked_nxt, err_flag_nxt;
    logic [ERR_W-1:0]      bit_cnt_nxt, byte_cnt_nxt;

    logic [7:0]            pat_byte;
    logic [3:0]            n_eff;
    logic [3:0]            rep_inc;
    lfsr_out_t             lfsr_adv;
    logic [3:0]            err_pop;
    logic [ERR_W:0]        bit_sum;
    logic [ERR_W-1:0]      bit_sat, byte_sat;
    logic [CONSEC_W-1:0]   consec_inc;

    always_comb begin
        case (byte_idx)
            2'd0:    pat_byte = pattern[31:24];
            2'd1:    pat_byte = pattern[23:16];
            2'd2:    pat_byte = pattern[15:8];
            default: pat_byte = pattern[7:0];
        endcase
    end

    assign n_eff      = (n == 4'd0) ? 4'd1 : n;
    assign rep_inc    = rep_cnt + 4'd1;
    assign lfsr_adv   = lfsr_step8(lfsr);
    assign err_pop    = 4'($countones(data_in ^ lfsr_adv.pred));
    assign bit_sum    = {1'b0, bit_err_cnt} + (ERR_W+1)'(err_pop);
    assign bit_sat    = bit_sum[ERR_W] ? '1 : bit_sum[ERR_W-1:0];
    assign byte_sat   = (&byte_err_cnt) ? byte_err_cnt : byte_err_cnt + 1'b1;
    assign consec_inc = consec_err + 1'b1;

    // NOTE: every signal gets its hold value first so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        byte_idx_nxt   = byte_idx;
        rep_cnt_nxt    = rep_cnt;
        seed_cnt_nxt   = seed_cnt;
        seed_byte_nxt  = seed_byte;
        lfsr_nxt       = lfsr;
        consec_err_nxt = consec_err;
        detected_nxt   = pattern_detected;
        locked_nxt     = prbs_locked;
        bit_cnt_nxt    = bit_err_cnt;
        byte_cnt_nxt   = byte_err_cnt;
        err_flag_nxt   = 1'b0;

        if (data_valid) begin
            case (state)
                HUNT: begin
                    if (data_in == pat_byte) begin
                        if (byte_idx == 2'd3) begin
                            byte_idx_nxt = 2'd0;
                            rep_cnt_nxt  = rep_inc;
                            if (rep_inc == n_eff) begin
                                detected_nxt = 1'b1;
                                state_nxt    = SEED;
                                seed_cnt_nxt = 1'b0;
                            end
                        end else begin
                            byte_idx_nxt = byte_idx + 2'd1;
                        end
                    end else begin
                        // A broken run may itself be the start of a new one.
                        rep_cnt_nxt  = 4'd0;
                        byte_idx_nxt = (data_in == pattern[31:24]) ? 2'd1 : 2'd0;
                    end
                end

                SEED: begin
                    if (!seed_cnt) begin
                        seed_byte_nxt = data_in;
                        seed_cnt_nxt  = 1'b1;
                    end else begin
                        lfsr_nxt   = {seed_byte[6:0], data_in};
                        state_nxt  = CHECK;
                        locked_nxt = 1'b1;
                    end
                end

                CHECK: begin
                    lfsr_nxt    = lfsr_adv.next;
                    bit_cnt_nxt = bit_sat;
                    if (err_pop != 4'd0) begin
                        byte_cnt_nxt = byte_sat;
                        err_flag_nxt = 1'b1;
                        if (consec_inc >= CONSEC_W'(LOSS_THRESH)) begin
                            state_nxt      = HUNT;
                            locked_nxt     = 1'b0;
                            detected_nxt   = 1'b0;
                            byte_idx_nxt   = 2'd0;
                            rep_cnt_nxt    = 4'd0;
                            consec_err_nxt = '0;
                        end else begin
                            consec_err_nxt = consec_inc;
                        end
                    end else begin
                        consec_err_nxt = '0;
                    end
                end

                default: state_nxt = HUNT;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= HUNT;
            byte_idx         <= 2'd0;
            rep_cnt          <= 4'd0;
            seed_cnt         <= 1'b0;
            seed_byte        <= 8'd0;
            lfsr             <= 15'd0;
            consec_err       <= '0;
            pattern_detected <= 1'b0;
            prbs_locked      <= 1'b0;
            bit_err_cnt      <= '0;
            byte_err_cnt     <= '0;
            err_flag         <= 1'b0;
        end else begin
            state            <= state_nxt;
            byte_idx         <= byte_idx_nxt;
            rep_cnt          <= rep_cnt_nxt;
            seed_cnt         <= seed_cnt_nxt;
            seed_byte        <= seed_byte_nxt;
            lfsr             <= lfsr_nxt;
            consec_err       <= consec_err_nxt;
            pattern_detected <= detected_nxt;
            prbs_locked      <= locked_nxt;
            bit_err_cnt      <= bit_cnt_nxt;
            byte_err_cnt     <= byte_cnt_nxt;
            err_flag         <= err_flag_nxt;
        end
    end

endmodule

// File: tb/tb_prbs_pattern_checker.sv
// Randomized bench for prbs_pattern_checker against a bit-sequence reference model;
// a 4-bit-counter instance shares the stimulus to exercise saturation.
module tb_prbs_pattern_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        data_valid;
    logic [31:0] pattern;
    logic [3:0]  n;

    logic        det, lock, flag;
    logic [15:0] bit_cnt, byte_cnt;
    logic        s_det, s_lock, s_flag;
    logic [3:0]  s_bit_cnt, s_byte_cnt;

    prbs_pattern_checker #(.ERR_W(16), .LOSS_THRESH(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .pattern(pattern), .n(n), .pattern_detected(det), .prbs_locked(lock),
        .bit_err_cnt(bit_cnt), .byte_err_cnt(byte_cnt), .err_flag(flag)
    );

    prbs_pattern_checker #(.ERR_W(4), .LOSS_THRESH(4)) dut_small (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .pattern(pattern), .n(n), .pattern_detected(s_det), .prbs_locked(s_lock),
        .bit_err_cnt(s_bit_cnt), .byte_err_cnt(s_byte_cnt), .err_flag(s_flag)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    string phase = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s/%s got=%0h exp=%0h", phase, tag, got, exp);
        end
    endtask

    // Reference model: 0=hunting, 1=seeding, 2=checking; the PRBS reference is
    // the last 15 expected bits, next bit = x[k-15] ^ x[k-14].
    int   m_st, m_idx, m_rep, m_consec, m_bit, m_byte;
    bit   m_seeded, m_det, m_lock, m_flag;
    bit [7:0] m_b0;
    bit   m_hist[$];

    task automatic model_reset();
        m_st = 0; m_idx = 0; m_rep = 0; m_consec = 0; m_bit = 0; m_byte = 0;
        m_seeded = 0; m_det = 0; m_lock = 0; m_flag = 0; m_b0 = 0;
        m_hist.delete();
    endtask

    task automatic model_byte(input bit [7:0] d);
        bit [7:0] pred;
        bit [7:0] first;
        bit       nb;
        int       pop, need;
        m_flag = 0;
        first  = pattern[31:24];
        case (m_st)
            0: begin
                need = (n == 0) ? 1 : int'(n);
                if (d == pattern[31-8*m_idx -: 8]) begin
                    m_idx++;
                    if (m_idx == 4) begin
                        m_idx = 0;
                        m_rep++;
                        if (m_rep == need) begin
                            m_det = 1; m_st = 1; m_seeded = 0;
                        end
                    end
                end else begin
                    m_rep = 0;
                    m_idx = (d == first) ? 1 : 0;
                end
            end
            1: begin
                if (!m_seeded) begin
                    m_b0 = d; m_seeded = 1;
                end else begin
                    m_hist.delete();
                    for (int i = 6; i >= 0; i--) m_hist.push_back(m_b0[i]);
                    for (int i = 7; i >= 0; i--) m_hist.push_back(d[i]);
                    m_st = 2; m_lock = 1;
                end
            end
            default: begin
                for (int i = 0; i < 8; i++) begin
                    nb = m_hist[0] ^ m_hist[1];
                    pred[7-i] = nb;
                    m_hist.push_back(nb);
                    void'(m_hist.pop_front());
                end
                pop   = $countones(d ^ pred);
                m_bit = (m_bit + pop > 65535) ? 65535 : m_bit + pop;
                if (pop > 0) begin
                    m_byte = (m_byte < 65535) ? m_byte + 1 : 65535;
                    m_flag = 1;
                    m_consec++;
                    if (m_consec == 4) begin
                        m_st = 0; m_lock = 0; m_det = 0; m_idx = 0; m_rep = 0; m_consec = 0;
                    end
                end else begin
                    m_consec = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("det",      det,        m_det);
        check("lock",     lock,       m_lock);
        check("flag",     flag,       m_flag);
        check("bit_cnt",  bit_cnt,    m_bit);
        check("byte_cnt", byte_cnt,   m_byte);
        check("s_lock",   s_lock,     m_lock);
        check("s_bit",    s_bit_cnt,  (m_bit  > 15) ? 15 : m_bit);
        check("s_byte",   s_byte_cnt, (m_byte > 15) ? 15 : m_byte);
    endtask

    task automatic cycle(input bit v, input bit [7:0] d);
        @(negedge clk);
        data_valid = v;
        data_in    = d;
        @(posedge clk);
        #1;
        if (v) model_byte(d);
        else   m_flag = 0;
        compare_all();
    endtask

    task automatic send(input bit [7:0] d);
        if ($urandom_range(0, 3) == 0) cycle(1'b0, 8'($urandom));
        cycle(1'b1, d);
    endtask

    // PRBS-15 source: a random nonzero 15-bit start, then x[k] = x[k-15] ^ x[k-14].
    bit g_bits[$];
    int g_pos;

    task automatic gen_init();
        bit nz;
        do begin
            g_bits.delete();
            nz = 0;
            for (int i = 0; i < 15; i++) begin
                g_bits.push_back(1'($urandom));
                nz |= g_bits[i];
            end
        end while (!nz);
        g_pos = 0;
    endtask

    task automatic gen_byte(output bit [7:0] b);
        for (int i = 0; i < 8; i++) begin
            while (g_bits.size() <= g_pos)
                g_bits.push_back(g_bits[g_bits.size()-15] ^ g_bits[g_bits.size()-14]);
            b[7-i] = g_bits[g_pos];
            g_pos++;
        end
    endtask

    task automatic send_pattern(input bit [31:0] pat, input bit [3:0] nn);
        int reps;
        pattern = pat;
        n       = nn;
        reps    = (nn == 0) ? 1 : int'(nn);
        for (int r = 0; r < reps; r++)
            for (int k = 0; k < 4; k++) send(pat[31-8*k -: 8]);
    endtask

    task automatic send_seed();
        bit [7:0] b;
        gen_init();
        gen_byte(b); send(b);
        gen_byte(b); send(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        data_valid = 1'b0;
        @(negedge clk);
        model_reset();
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        bit [7:0] b;
        bit [7:0] seq6 [6];

        rst = 1'b1; data_valid = 1'b0; data_in = 8'h00; pattern = 32'h0; n = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        phase = "reset";
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        phase = "detect_n3";
        pattern = 32'hA5A6A7A8;
        n = 4'd3;
        for (int i = 0; i < 12; i++) begin
            send(pattern[31-8*(i%4) -: 8]);
            if (i == 10) check("det_before_12th", det, 1'b0);
        end
        check("det_on_12th", det, 1'b1);
        check("lock_after_detect", lock, 1'b0);

        phase = "clean_prbs";
        send_seed();
        check("lock_after_seed", lock, 1'b1);
        for (int i = 0; i < 100; i++) begin
            gen_byte(b);
            send(b);
        end
        check("bit_cnt_clean", bit_cnt, 16'd0);
        check("byte_cnt_clean", byte_cnt, 16'd0);

        phase = "flip_0_5";
        gen_byte(b);
        cycle(1'b1, b ^ 8'h21);
        check("bit_cnt_two", bit_cnt, 16'd2);
        check("byte_cnt_one", byte_cnt, 16'd1);
        check("flag_pulse", flag, 1'b1);
        gen_byte(b);
        cycle(1'b1, b);
        check("flag_one_cycle", flag, 1'b0);
        check("lock_held", lock, 1'b1);

        phase = "restart_idx1";
        do_reset();
        pattern = 32'hA5A6A7A8;
        n = 4'd1;
        seq6 = '{8'hA5, 8'hA6, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, seq6[i]);
            if (i == 4) check("det_before_6th", det, 1'b0);
        end
        check("det_on_6th", det, 1'b1);

        phase = "loss_of_lock";
        send_seed();
        for (int i = 0; i < 10; i++) begin
            gen_byte(b);
            send(b);
        end
        for (int i = 0; i < 4; i++) begin
            gen_byte(b);
            send(b ^ 8'($urandom_range(1, 255)));
            if (i == 2) check("lock_after_3_bad", lock, 1'b1);
        end
        check("lock_dropped", lock, 1'b0);
        check("det_dropped", det, 1'b0);
        check("byte_cnt_four", byte_cnt, 16'd4);

        phase = "random";
        for (int round = 0; round < 12; round++) begin
            for (int i = 0; i < 6; i++) send(8'($urandom));
            send_pattern($urandom, 4'($urandom_range(0, 3)));
            send_seed();
            for (int i = 0; i < 40; i++) begin
                gen_byte(b);
                if ($urandom_range(0, 7) == 0) b ^= 8'($urandom);
                send(b);
            end
        end

        phase = "saturate";
        do_reset();
        send_pattern(32'h1234ABCD, 4'd1);
        send_seed();
        for (int i = 0; i < 20; i++) begin
            gen_byte(b); send(b ^ 8'hFF);
            gen_byte(b); send(b);
        end
        check("s_byte_sat", s_byte_cnt, 4'hF);
        check("s_bit_sat", s_bit_cnt, 4'hF);
        check("s_lock_kept", s_lock, 1'b1);
        check("byte_cnt_20", byte_cnt, 16'd20);
        check("bit_cnt_160", bit_cnt, 16'd160);

        phase = "async_reset";
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_det", det, 1'b0);
        check("rst_lock", lock, 1'b0);
        check("rst_flag", flag, 1'b0);
        check("rst_bit", bit_cnt, 16'd0);
        check("rst_byte", byte_cnt, 16'd0);
        check("rst_s_bit", s_bit_cnt, 4'd0);
        check("rst_s_byte", s_byte_cnt, 4'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send(8'h12);
        send(8'h34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prbs_pattern_checker.md
Name: prbs_pattern_checker

Overview:
- Receive-side checker directly downstream of the PRBS/pattern generator top level; consumes its 8-bit byte stream.
- Hunts for the 32-bit sync pattern repeated n times back-to-back.
- Then self-seeds a PRBS-15 reference and counts bit and byte errors on every following byte.
- Reports detection, lock and error statistics to the bench and the status logic.

Parameters:
- ERR_W, 16, width of the bit-error and byte-error counters; both saturate at all-ones.
- LOSS_THRESH, 4, number of consecutive errored bytes in CHECK that drops lock.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  8  received byte (prbs_out of the generator).
- data_valid  input  1  data_in is valid this cycle; bytes with data_valid=0 are ignored, and no state changes occur.
- pattern  input  32  sync pattern. Bytes arrive MSB first: pattern[31:24], [23:16], [15:8], [7:0].
- n  input  4  required consecutive pattern repetitions; n=0 is treated as 1. Sampled live, so it must be held stable outside reset.
- pattern_detected  output  1  level; high once n repetitions are seen, until reset or loss of lock.
- prbs_locked  output  1  high while in CHECK.
- bit_err_cnt  output  ERR_W  total mismatched bits in CHECK, saturating.
- byte_err_cnt  output  ERR_W  total bytes with at least one mismatch in CHECK, saturating.
- err_flag  output  1  registered one-cycle pulse for each errored byte in CHECK.

Behaviour:
- Reset (async assert, sync release): state=HUNT, byte_idx=0, rep_cnt=0, LFSR=0, all outputs 0, counters 0.
- All logic is registered. Outputs update on the clock edge that consumes the relevant valid byte (latency 1 cycle from the data_valid sample).

HUNT:
- Compare data_in with pattern byte[byte_idx].
- Match: byte_idx increments. On byte_idx=3, byte_idx wraps to 0 and rep_cnt increments.
- When rep_cnt reaches max(n,1): pattern_detected<=1, go to SEED, seed_cnt=0.
- Mismatch: rep_cnt<=0. If data_in equals pattern[31:24], byte_idx<=1; else byte_idx<=0.

SEED:
- Capture two valid bytes b0 then b1.
- On b1: LFSR<=({b0,b1})[14:0], i.e. {b0[6:0],b1}, oldest bit in MSB. Go to CHECK, prbs_locked<=1.
- No error counting in SEED.

CHECK:
- Predicted byte: 8 LFSR steps per byte. Each step: new=s[14]^s[13]; s<={s[13:0],new}. The first new bit is the expected data_in[7].
- Advance the LFSR by 8 steps on every valid byte, regardless of error.
- Error bits: popcount(data_in ^ predicted), 0..8.
- Add the popcount to bit_err_cnt, saturating; no wrap.
- If nonzero: increment byte_err_cnt (saturating), pulse err_flag, increment consec_err. Otherwise consec_err<=0.
- If consec_err reaches LOSS_THRESH: go to HUNT. Clear prbs_locked, pattern_detected, byte_idx, rep_cnt. Counters are retained.

Boundaries and global rules:
- Reset mid-stream returns to HUNT immediately (async).
- Counters clear only on rst.
- data_valid low in any state holds all state.

Test Plan:
- rst pulse, then stream A5 A6 A7 A8 ×3 with n=3 and pattern=32'hA5A6A7A8 -> pattern_detected rises on the edge sampling the 12th byte; prbs_locked=0.
- Continue with a correct PRBS-15 byte stream from the generator -> prbs_locked=1 after the 2 seed bytes; bit_err_cnt=0 and byte_err_cnt=0 after 100 bytes.
- Flip data_in bits 0 and 5 on one CHECK byte -> bit_err_cnt=2, byte_err_cnt=1, err_flag high for exactly 1 cycle; lock held.
- Stream A5 A6 A5 A6 A7 A8 with n=1 -> mismatch on the 3rd byte restarts at idx 1; detection occurs on byte 6.
- Corrupt 4 consecutive CHECK bytes (LOSS_THRESH=4) -> prbs_locked and pattern_detected drop on the 4th byte; state=HUNT; byte_err_cnt=4.
- Preload near saturation by forcing 0xFFFF errored bytes (or ERR_W=4 with 20 errored bytes) -> counters hold at all-ones; assert rst mid-CHECK -> all outputs 0 immediately.
